// File: rtl/mssd_datapath.sv
// mssd_datapath: payload stage of the serial demultiplexer.
// Packs MSB-first bits into bytes and steers them to a channel.
module mssd_datapath #(
    parameter  int DATA_W = 8,
    parameter  int CH_W   = 2,
    parameter  int LEN_W  = 4,
    localparam int NCH    = 2 ** CH_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serIn,
    input  logic                  dataCom,
    input  logic [CH_W-1:0]       dest,
    input  logic [LEN_W-1:0]      bCounter,
    output logic [NCH*DATA_W-1:0] dataOut,
    output logic [NCH-1:0]        valid,
    output logic                  frameDone,
    output logic                  lenErr,
    output logic                  busy
);

    localparam int BCW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [BCW-1:0]        bitcnt_q, bitcnt_d;
    logic [LEN_W-1:0]      bytecnt_q, bytecnt_d;
    logic [CH_W-1:0]       dest_q, dest_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [NCH*DATA_W-1:0] dout_q, dout_d;
    logic [NCH-1:0]        valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic [DATA_W-1:0]     shifted;
    logic                  last_bit;
    logic                  last_byte;

    assign shifted   = {shift_q[DATA_W-2:0], serIn};
    assign last_bit  = (bitcnt_q == BCW'(DATA_W - 1));
    assign last_byte = (LEN_W'(bytecnt_q + 1'b1) == len_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        dest_d    = dest_q;
        len_d     = len_q;
        dout_d    = dout_q;
        valid_d   = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dataCom) begin
                    dest_d = dest;
                    len_d  = bCounter;
                    if (bCounter != '0) begin
                        shift_d   = shifted;
                        bitcnt_d  = BCW'(1);
                        bytecnt_d = '0;
                        state_d   = RECV;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            RECV: begin
                if (dataCom) begin
                    shift_d = shifted;
                    if (last_bit) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (dest_q == CH_W'(c)) begin
                                dout_d[c*DATA_W +: DATA_W] = shifted;
                                valid_d[c] = 1'b1;
                            end
                        end
                        bitcnt_d  = '0;
                        bytecnt_d = LEN_W'(bytecnt_q + 1'b1);
                        if (last_byte) begin
                            done_d  = 1'b1;
                            state_d = DRAIN;
                        end
                    end else begin
                        bitcnt_d = BCW'(bitcnt_q + 1'b1);
                    end
                end else begin
                    // Payload ended early: drop the partial byte.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!dataCom) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            dest_q    <= '0;
            len_q     <= '0;
            dout_q    <= '0;
            valid_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            bytecnt_q <= bytecnt_d;
            dest_q    <= dest_d;
            len_q     <= len_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign dataOut   = dout_q;
    assign valid     = valid_q;
    assign frameDone = done_q;
    assign lenErr    = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mssd_datapath.sv
// tb_mssd_datapath: directed and random frames against a
// frame-level reference model of the payload stage.
module tb_mssd_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        serIn;
    logic        dataCom;
    logic [1:0]  dest;
    logic [3:0]  bCounter;
    logic [31:0] dataOut;
    logic [3:0]  valid;
    logic        frameDone;
    logic        lenErr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] chan [4];

    mssd_datapath dut (
        .clk      (clk),
        .reset    (reset),
        .serIn    (serIn),
        .dataCom  (dataCom),
        .dest     (dest),
        .bCounter (bCounter),
        .dataOut  (dataOut),
        .valid    (valid),
        .frameDone(frameDone),
        .lenErr   (lenErr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ev,
                             input logic ed, input logic ee,
                             input logic eb);
        chk({tag, "_valid"}, 64'(valid), 64'(ev));
        chk({tag, "_done"}, 64'(frameDone), 64'(ed));
        chk({tag, "_lenerr"}, 64'(lenErr), 64'(ee));
        chk({tag, "_busy"}, 64'(busy), 64'(eb));
        chk({tag, "_data"}, 64'(dataOut),
            64'({chan[3], chan[2], chan[1], chan[0]}));
    endtask

    task automatic clear_chan();
        for (int c = 0; c < 4; c++) chan[c] = 8'h00;
    endtask

    task automatic idle(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            reset    = 1'b0;
            dataCom  = 1'b0;
            serIn    = 1'($urandom);
            dest     = 2'($urandom);
            bCounter = 4'($urandom);
            @(posedge clk);
            #1;
            check_all(tag, 4'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One frame: dataCom high for n edges, then low for one edge.
    // Bit for edge e is pl[n-1-e]; reset optionally hits at edge rst_at.
    task automatic run_frame(input string tag, input int d, input int len,
                             input int n, input logic [127:0] pl,
                             input int rst_at);
        int last;
        logic [3:0] ev;
        logic ed, ee, eb;
        last = (rst_at >= 0) ? rst_at : n;
        for (int e = 0; e <= last; e++) begin
            dataCom = (e < n);
            serIn   = (e < n) ? pl[n-1-e] : 1'($urandom);
            if (e == 0) begin
                dest     = 2'(d);
                bCounter = 4'(len);
            end else begin
                dest     = 2'((d + 1 + int'($urandom_range(0, 2))) % 4);
                bCounter = 4'($urandom);
            end
            reset = (e == rst_at);
            @(posedge clk);
            #1;
            if (e == rst_at) begin
                clear_chan();
                check_all({tag, "_rst"}, 4'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                ev = 4'b0;
                if (len > 0 && e < n && (e % 8) == 7 && (e / 8) < len) begin
                    ev[d]   = 1'b1;
                    chan[d] = 8'((pl >> (n - 8 * (e / 8 + 1))) & 128'hFF);
                end
                ed = (len > 0 && e == 8 * len - 1 && e < n);
                ee = (len == 0 && e == 0) ||
                     (len > 0 && e == n && n < 8 * len);
                eb = (e < n);
                check_all(tag, ev, ed, ee, eb);
            end
        end
        if (rst_at >= 0) begin
            reset   = 1'b0;
            dataCom = 1'b0;
            @(posedge clk);
            #1;
            check_all({tag, "_post"}, 4'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int d, len, n;
        logic [127:0] pl;

        reset    = 1'b1;
        dataCom  = 1'b1;
        serIn    = 1'b0;
        dest     = 2'd0;
        bCounter = 4'd1;
        clear_chan();
        for (int i = 0; i < 2; i++) begin
            serIn = ~serIn;
            @(posedge clk);
            #1;
            check_all("reset", 4'b0, 1'b0, 1'b0, 1'b0);
        end
        idle("idle0", 2);

        run_frame("single_a5", 2, 1, 8, 128'hA5, -1);
        idle("gap", 1);
        run_frame("three_bytes", 0, 3, 24, 128'h01FF80, -1);
        idle("gap", 2);
        run_frame("short", 1, 2, 12, 128'h3C5, -1);
        idle("gap", 1);
        run_frame("zero_len", 3, 0, 10, 128'h2AB, -1);
        idle("gap", 1);
        run_frame("abort", 2, 1, 8, 128'hFF, 5);
        run_frame("after_rst", 1, 1, 8, 128'h5A, -1);
        idle("gap", 1);
        run_frame("max_len", 3, 15, 124, {4{32'hC3A5_1E96}}, -1);
        idle("gap", 1);

        for (int k = 0; k < 30; k++) begin
            d   = int'($urandom_range(0, 3));
            len = int'($urandom_range(0, 15));
            pl  = {$urandom, $urandom, $urandom, $urandom};
            if (len == 0)
                n = int'($urandom_range(1, 10));
            else if ($urandom_range(0, 2) == 0)
                n = int'($urandom_range(1, 8 * len - 1));
            else
                n = 8 * len + int'($urandom_range(0, 4));
            run_frame("rand", d, len, n, pl, -1);
            idle("rgap", int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
